uart_rx: RTL and testbench

UART receiver: the receive end of the team's 8N1 serial link, paired with uart_tx. Synchronises the asynchronous rx line, detects the start bit, mid-bit samples DBIT data bits LSB-first, and checks the stop bit. It then presents the byte on a valid/ready holding register to the bus-side consumer, e.g. a memory-mapped UART peripheral on the RISC-V core.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync.sv | 25 ++
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry, line idle level.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int   DEF_DBIT         = 8;
  localparam int   DEF_CLKS_PER_BIT = 16;
  localparam logic LINE_IDLE        = 1'b1;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; 2 cycles latency, no backpressure.
module uart_sync
  import uart_pkg::*;
#(
  parameter logic RST_VAL = LINE_IDLE
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling; byte appears 155 cycles after the start edge at defaults.
// Valid/ready holding register: a byte completing while the register is full is dropped (overrun).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT         = DEF_DBIT,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] d_rx,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int HALF = CLKS_PER_BIT / 2;

  logic            rx_s;
  rx_state_t       state;
  logic [TW-1:0]   tick;
  logic [BW-1:0]   bit_cnt;
  logic [DBIT-1:0] sh;
  logic [7:0]      byte_ext;
  logic [1:0]      settle;
  logic            armed;

  uart_sync #(.RST_VAL(LINE_IDLE)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign byte_ext = 8'(sh);

  // After reset the synchroniser holds a fake idle level for two cycles; only once it
  // carries the real line is the receiver armed, and a line found low waits for a break.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tick      <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      settle    <= '0;
      armed     <= 1'b0;
      d_rx      <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (settle != 2'd2) settle <= settle + 2'd1;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!armed) begin
            if (settle == 2'd2) begin
              if (rx_s == LINE_IDLE) armed <= 1'b1;
              else                   state <= WAIT_HIGH;
            end
          end else if (rx_s != LINE_IDLE) begin
            state <= START;
            tick  <= '0;
          end
        end

        START: begin
          if (tick == TW'(HALF - 1)) begin
            tick    <= '0;
            bit_cnt <= '0;
            state   <= (rx_s != LINE_IDLE) ? DATA : IDLE;
          end else begin
            tick <= tick + 1'b1;
          end
        end

        DATA: begin
          if (tick == TW'(CLKS_PER_BIT - 1)) begin
            tick <= '0;
            sh   <= (sh >> 1) | (DBIT'(rx_s) << (DBIT - 1));
            if (bit_cnt == BW'(DBIT - 1)) state <= STOP;
            else                          bit_cnt <= bit_cnt + 1'b1;
          end else begin
            tick <= tick + 1'b1;
          end
        end

        STOP: begin
          if (tick == TW'(CLKS_PER_BIT - 1)) begin
            tick <= '0;
            if (rx_s == LINE_IDLE) begin
              state <= IDLE;
              // Loading overrides the handshake clear above when both happen together.
              if (!rx_valid || rx_ready) begin
                d_rx     <= byte_ext;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              state     <= WAIT_HIGH;
              frame_err <= 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

        WAIT_HIGH: begin
          if (rx_s == LINE_IDLE) begin
            state <= IDLE;
            armed <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed frames into uart_rx; a negedge monitor pops expected bytes on each handshake.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       rx_ready;
  logic [7:0] d_rx;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int         vectors;
  int         miscompares;
  int         cyc;
  int         t0;
  int         fe_cnt;
  int         ov_cnt;
  logic [7:0] exp_q[$];

  uart_rx #(.DBIT(8), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_ready  (rx_ready),
    .d_rx      (d_rx),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (frame_err || overrun) check("pulse_exclusive", 32'(frame_err & overrun), 0);
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_byte: got %0h, expected none", d_rx);
        end else begin
          check("byte", 32'(d_rx), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(CPB);
    end
    rx = stop_bit;
    wait_cycles(CPB);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    fe_cnt      = 0;
    ov_cnt      = 0;
    rx          = 1'b1;
    rx_ready    = 1'b1;
    reset       = 1'b1;
    #2 reset    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_d_rx", 32'(d_rx), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    reset = 1'b1;
    wait_cycles(10);

    // 0xA5: latency from rx fall and single-cycle valid with rx_ready held high
    exp_q.push_back(8'hA5);
    t0 = cyc;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 200 && !rx_valid; i++) @(negedge clk);
        check("latency_a5", 32'(cyc - t0), 155);
        @(negedge clk);
        check("valid_one_cycle", 32'(rx_valid), 0);
      end
    join
    wait_cycles(20);
    check("a5_fe", 32'(fe_cnt), 0);
    check("a5_ov", 32'(ov_cnt), 0);

    // 4-cycle low glitch is rejected at mid-start
    rx = 1'b0;
    wait_cycles(4);
    rx = 1'b1;
    wait_cycles(40);
    check("glitch_valid", 32'(rx_valid), 0);
    check("glitch_fe", 32'(fe_cnt), 0);
    check("glitch_ov", 32'(ov_cnt), 0);

    // 0x3C with bad stop bit, line held low, then 0x81 after a break
    send_frame(8'h3C, 1'b0);
    wait_cycles(40);
    check("ferr_pulse", 32'(fe_cnt), 1);
    check("ferr_valid", 32'(rx_valid), 0);
    rx = 1'b1;
    wait_cycles(20);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    wait_cycles(20);
    check("ferr_once", 32'(fe_cnt), 1);

    // back-to-back 0x11, 0x22 with consumer stalled
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_cycles(20);
    check("ovr_pulse", 32'(ov_cnt), 1);
    check("ovr_d_rx", 32'(d_rx), 32'h11);
    check("ovr_valid", 32'(rx_valid), 1);
    rx_ready = 1'b1;
    wait_cycles(3);
    check("ovr_drained", 32'(rx_valid), 0);

    // 0x55 held, rx_ready pulsed exactly on the completion cycle of 0x66
    rx_ready = 1'b0;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    wait_cycles(10);
    check("hold_d_rx", 32'(d_rx), 32'h55);
    check("hold_valid", 32'(rx_valid), 1);
    exp_q.push_back(8'h66);
    t0 = cyc;
    fork
      send_frame(8'h66, 1'b1);
      begin
        wait_cycles(154);
        rx_ready = 1'b1;
        wait_cycles(1);
        rx_ready = 1'b0;
      end
    join
    check("simul_d_rx", 32'(d_rx), 32'h66);
    check("simul_valid", 32'(rx_valid), 1);
    check("simul_ov", 32'(ov_cnt), 1);
    rx_ready = 1'b1;
    wait_cycles(5);
    check("simul_drained", 32'(rx_valid), 0);

    // reset mid-DATA of 0xF0, released while line is still low, then 0x0F
    rx = 1'b0;
    wait_cycles(CPB + 40);
    reset = 1'b0;
    wait_cycles(5);
    check("midrst_d_rx", 32'(d_rx), 0);
    check("midrst_valid", 32'(rx_valid), 0);
    reset = 1'b1;
    wait_cycles(20);
    rx = 1'b1;
    wait_cycles(32);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    wait_cycles(30);

    check("queue_empty", 32'(exp_q.size()), 0);
    check("final_fe", 32'(fe_cnt), 1);
    check("final_ov", 32'(ov_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
